mem_access_stage: RTL and testbench

- Multi-cycle memory-access stage between the ALU (effective address) and register writeback for the MIPS core.
- Accepts one load/store per handshake and drives a ready/valid data-memory port, holding the request until memory responds.
- Byte-lane extracts and sign/zero-extends loads; builds byte strobes for stores.
- Emits a one-cycle writeback pulse for loads and flags misaligned accesses instead of issuing them.

---
 rtl/mem_access_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: multi-cycle load/store stage between the ALU and writeback.
// Accepts one memory op per handshake, drives a ready/valid data-memory port
// (holding the request until mem_ready), extends load data and pulses writeback.
// Misaligned accesses are flagged on misalign and never issued.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       op handshake from the ALU (in_ready only in IDLE)
//   opcode/address          MIPS opcode and effective byte address
//   store_data/dest_reg     rt content for stores, rt index for loads
//   mem_req/mem_we          memory request and write enable
//   mem_addr                word address (address[ADDR_W-1:2])
//   mem_wdata/mem_wstrb     lane-replicated store data and byte enables
//   mem_ready/mem_rdata     memory completion and read word
//   wb_valid/wb_reg/wb_data one-cycle load writeback
//   misalign                one-cycle misaligned (or timed-out) access flag
//   busy                    stage not idle, stalls PC update
//
// Optional: define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES
// wait cycles without mem_ready (reported on misalign).
module mem_access_stage #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       store_data,
    input  logic [4:0]        dest_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic [31:0]       wb_data,
    output logic              misalign,
    output logic              busy
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [5:0]        r_op;
    logic [1:0]        r_lane;
    logic [4:0]        r_dest;

    logic              w_capture;
    logic              w_timed_out;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_misaligned;
    logic              w_r_is_load;
    logic [31:0]       w_st_data;
    logic [3:0]        w_st_strb;
    logic [31:0]       w_ld_data;

    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-3:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic [3:0]        w_mem_wstrb;
    logic              w_wb_valid;
    logic [4:0]        w_wb_reg;
    logic [31:0]       w_wb_data;
    logic              w_misalign;

    // Incoming op decode and alignment check
    always_comb begin
        w_is_load    = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                       (opcode == OP_LBU) || (opcode == OP_LHU);
        w_is_store   = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
        w_misaligned = (((opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH)) && address[0]) ||
                       (((opcode == OP_LW) || (opcode == OP_SW)) && (address[1:0] != 2'b00));
    end

    // Store lane replication and byte enables
    always_comb begin
        w_st_data = store_data;
        w_st_strb = 4'b0000;
        case (opcode)
            OP_SB: begin
                w_st_data = {4{store_data[7:0]}};
                w_st_strb = 4'b0001 << address[1:0];
            end
            OP_SH: begin
                w_st_data = {2{store_data[15:0]}};
                w_st_strb = address[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW:   w_st_strb = 4'b1111;
            default: w_st_data = 32'h0;
        endcase
    end

    // Load lane extraction and sign/zero extension from the captured op
    always_comb begin
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        v_byte      = mem_rdata[{r_lane, 3'b000} +: 8];
        v_half      = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_r_is_load = 1'b1;
        case (r_op)
            OP_LB:   w_ld_data = {{24{v_byte[7]}}, v_byte};
            OP_LBU:  w_ld_data = {24'h0, v_byte};
            OP_LH:   w_ld_data = {{16{v_half[15]}}, v_half};
            OP_LHU:  w_ld_data = {16'h0, v_half};
            OP_LW:   w_ld_data = mem_rdata;
            default: begin
                w_ld_data   = 32'h0;
                w_r_is_load = 1'b0;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter, cleared when a request is issued
    always_ff @(posedge clock) begin
        if (reset || w_capture) begin
            r_count <= '0;
        end else if ((r_state == S_REQ) && !mem_ready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_timed_out = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timed_out      = 1'b0;
`endif

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = 32'h0;
        w_mem_wstrb = 4'b0000;
        w_wb_valid  = 1'b0;
        w_wb_reg    = 5'd0;
        w_wb_data   = 32'h0;
        w_misalign  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Non-memory opcodes are consumed here with no effect
                if (in_valid && (w_is_load || w_is_store)) begin
                    if (w_misaligned) begin
                        w_state_nxt = S_ERR;
                        w_misalign  = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_capture   = 1'b1;
                        w_mem_req   = 1'b1;
                        w_mem_we    = w_is_store;
                        w_mem_addr  = address[ADDR_W-1:2];
                        w_mem_wdata = w_st_data;
                        w_mem_wstrb = w_st_strb;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_state_nxt = S_RESP;
                    w_wb_valid  = w_r_is_load;
                    w_wb_reg    = w_r_is_load ? r_dest : 5'd0;
                    w_wb_data   = w_ld_data;
                end else if (w_timed_out) begin
                    w_state_nxt = S_ERR;
                    w_misalign  = 1'b1;
                end else begin
                    // Hold the request stable until memory responds
                    w_mem_req   = 1'b1;
                    w_mem_we    = mem_we;
                    w_mem_addr  = mem_addr;
                    w_mem_wdata = mem_wdata;
                    w_mem_wstrb = mem_wstrb;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, captured op and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 6'd0;
            r_lane    <= 2'd0;
            r_dest    <= 5'd0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            wb_valid  <= 1'b0;
            wb_reg    <= 5'd0;
            wb_data   <= 32'h0;
            misalign  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            if (w_capture) begin
                r_op   <= opcode;
                r_lane <= address[1:0];
                r_dest <= dest_reg;
            end
            in_ready  <= (w_state_nxt == S_IDLE);
            busy      <= (w_state_nxt != S_IDLE);
            mem_req   <= w_mem_req;
            mem_we    <= w_mem_we;
            mem_addr  <= w_mem_addr;
            mem_wdata <= w_mem_wdata;
            mem_wstrb <= w_mem_wstrb;
            wb_valid  <= w_wb_valid;
            wb_reg    <= w_wb_reg;
            wb_data   <= w_wb_data;
            misalign  <= w_misalign;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scoreboard of expected writebacks.
module tb_mem_access_stage;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TMO    = 4;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] address;
    logic [31:0]       store_data;
    logic [4:0]        dest_reg;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              misalign;
    logic              busy;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .address(address), .store_data(store_data), .dest_reg(dest_reg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .misalign(misalign), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // wb_valid and misalign must never coincide
    always @(negedge clock) begin
        if (chk_en) begin
            n_tests++;
            if ((wb_valid & misalign) !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_misalign_excl: wb_valid=%b misalign=%b exp not both", wb_valid, misalign);
            end
        end
    end

    // Present one op for a single accepting edge; returns at the next negedge
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        opcode     = op;
        address    = a;
        store_data = sd;
        dest_reg   = rd;
        in_valid   = 1'b1;
        @(negedge clock);
        in_valid   = 1'b0;
        opcode     = 6'h3F;
        address    = $urandom;
        store_data = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; opcode = 6'h0; address = '0;
        store_data = '0; dest_reg = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clock);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got=%b exp=1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got=%b exp=0", busy); end
        n_tests++; if ({mem_req, mem_we, mem_wstrb} !== 6'b0) begin n_fail++; $display("FAIL rst_mem_ctl: got=%b exp=0", {mem_req, mem_we, mem_wstrb}); end
        n_tests++; if ({mem_addr, mem_wdata} !== 62'b0) begin n_fail++; $display("FAIL rst_mem_data: got=%h exp=0", {mem_addr, mem_wdata}); end
        n_tests++; if ({wb_valid, wb_reg, wb_data, misalign} !== 39'b0) begin n_fail++; $display("FAIL rst_wb: got=%h exp=0", {wb_valid, wb_reg, wb_data, misalign}); end
        reset = 1'b0;
        @(negedge clock);
        chk_en = 1'b1;
    endtask

    task automatic test_lw_basic();
        wb_t e;
        sb_q.push_back('{rd: 5'd7, data: 32'hDEADBEEF});
        issue(6'h23, 32'h10, 32'h0, 5'd7);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_req: got=%b exp=1", mem_req); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got=%b exp=0", mem_we); end
        n_tests++; if (mem_addr !== 30'h4) begin n_fail++; $display("FAIL lw_addr: got=%h exp=4", mem_addr); end
        n_tests++; if (mem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lw_wstrb: got=%b exp=0000", mem_wstrb); end
        n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL lw_busy: got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clock);
        mem_ready = 1'b0; mem_rdata = $urandom;
        n_tests++;
        if (wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL lw_latency: wb_valid got=%b exp=1 two cycles after accept", wb_valid);
        end else begin
            e = sb_q.pop_front();
            if (wb_reg !== e.rd || wb_data !== e.data) begin
                n_fail++; $display("FAIL lw_data: got reg=%0d data=%h exp reg=%0d data=%h", wb_reg, wb_data, e.rd, e.data);
            end
        end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got=%b exp=0", mem_req); end
        @(negedge clock);
        n_tests++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL lw_after: wb_valid=%b in_ready=%b exp 0/1", wb_valid, in_ready); end
        sb_q.delete();
    endtask

    task automatic test_load_lanes();
        logic [5:0]  ops   [8] = '{6'h20, 6'h24, 6'h20, 6'h24, 6'h21, 6'h25, 6'h21, 6'h23};
        logic [31:0] addrs [8] = '{32'h13, 32'h13, 32'h12, 32'h11, 32'h12, 32'h12, 32'h00, 32'h0C};
        logic [31:0] exps  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h00000012,
                                   32'hFFFF80FF, 32'h000080FF, 32'h00001234, 32'h80FF1234};
        logic [4:0]  rds   [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd31, 5'd0};
        wb_t e;
        bit  got;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{rd: rds[i], data: exps[i]});
            issue(ops[i], addrs[i], 32'h0, rds[i]);
            repeat (i % 3) begin
                mem_rdata = $urandom;
                @(negedge clock);
            end
            mem_ready = 1'b1; mem_rdata = 32'h80FF1234;
            @(negedge clock);
            mem_ready = 1'b0; mem_rdata = $urandom;
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                if (wb_valid === 1'b1) got = 1'b1;
                else @(negedge clock);
            end
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL load_%0d_timeout: no wb_valid exp one pulse", i);
            end else if (sb_q.size() == 0) begin
                n_fail++; $display("FAIL load_%0d_unexpected: wb_valid with empty scoreboard", i);
            end else begin
                e = sb_q.pop_front();
                if (wb_reg !== e.rd || wb_data !== e.data) begin
                    n_fail++; $display("FAIL load_%0d_data: got reg=%0d data=%h exp reg=%0d data=%h", i, wb_reg, wb_data, e.rd, e.data);
                end
            end
            @(negedge clock);
            n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL load_%0d_pulse: wb_valid got=%b exp=0", i, wb_valid); end
        end
        sb_q.delete();
    endtask

    task automatic test_stores();
        logic [5:0]  ops   [4] = '{6'h29, 6'h28, 6'h28, 6'h2B};
        logic [31:0] addrs [4] = '{32'h06, 32'h05, 32'h03, 32'h08};
        logic [31:0] sds   [4] = '{32'h0000ABCD, 32'h12345678, 32'h12345678, 32'hCAFEF00D};
        logic [29:0] eaddr [4] = '{30'h1, 30'h1, 30'h0, 30'h2};
        logic [3:0]  estrb [4] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111};
        logic [31:0] edata [4] = '{32'hABCDABCD, 32'h78787878, 32'h78787878, 32'hCAFEF00D};
        int          dly   [4] = '{3, 0, 1, 2};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], addrs[i], sds[i], 5'd9);
            for (int c = 0; c <= dly[i]; c++) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== eaddr[i] ||
                    mem_wstrb !== estrb[i] || mem_wdata !== edata[i]) begin
                    n_fail++;
                    $display("FAIL store_%0d_cyc%0d: got req=%b we=%b addr=%h strb=%b wdata=%h exp 1 1 %h %b %h",
                             i, c, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, eaddr[i], estrb[i], edata[i]);
                end
                if (c == dly[i]) mem_ready = 1'b1;
                @(negedge clock);
            end
            mem_ready = 1'b0;
            n_tests++;
            if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL store_%0d_resp: got req=%b wb_valid=%b exp 0/0", i, mem_req, wb_valid);
            end
            @(negedge clock);
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL store_%0d_idle: in_ready got=%b exp=1", i, in_ready); end
        end
    endtask

    task automatic test_misalign();
        logic [5:0]  ops   [4] = '{6'h23, 6'h21, 6'h2B, 6'h29};
        logic [31:0] addrs [4] = '{32'h02, 32'h01, 32'h01, 32'h03};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            issue(ops[i], addrs[i], 32'h5A5A5A5A, 5'd3);
            n_tests++;
            if (misalign !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL misalign_%0d_pulse: got mis=%b req=%b wb=%b rdy=%b exp 1 0 0 0",
                                   i, misalign, mem_req, wb_valid, in_ready);
            end
            @(negedge clock);
            n_tests++;
            if (misalign !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL misalign_%0d_after: got mis=%b req=%b rdy=%b wb=%b exp 0 0 1 0",
                                   i, misalign, mem_req, in_ready, wb_valid);
            end
            mem_ready = 1'b0;
        end
    endtask

    task automatic test_unsupported();
        issue(6'h00, 32'h10, 32'h1, 5'd3);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || misalign !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL unsupported: got rdy=%b busy=%b req=%b mis=%b wb=%b exp 1 0 0 0 0",
                               in_ready, busy, mem_req, misalign, wb_valid);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        wb_t e;
        bit  got;
        issue(6'h23, 32'h20, 32'h0, 5'd1);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got=%b exp=1", mem_req); end
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_state: got req=%b busy=%b rdy=%b exp 0 0 1", mem_req, busy, in_ready);
        end
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clock);
        mem_ready = 1'b0;
        n_tests++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got wb=%b busy=%b exp 0 0", wb_valid, busy); end
        sb_q.push_back('{rd: 5'd9, data: 32'hFFFF8001});
        issue(6'h21, 32'h00, 32'h0, 5'd9);
        mem_ready = 1'b1; mem_rdata = 32'h12348001;
        @(negedge clock);
        mem_ready = 1'b0; mem_rdata = $urandom;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (wb_valid === 1'b1) got = 1'b1;
            else @(negedge clock);
        end
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL rmid_lh_timeout: no wb_valid exp one pulse");
        end else begin
            e = sb_q.pop_front();
            if (wb_reg !== e.rd || wb_data !== e.data) begin
                n_fail++; $display("FAIL rmid_lh_data: got reg=%0d data=%h exp reg=%0d data=%h", wb_reg, wb_data, e.rd, e.data);
            end
        end
        @(negedge clock);
        sb_q.delete();
    endtask

    task automatic test_back_to_back();
        int  acc   = 0;
        int  npul  = 0;
        int  pcyc  [3];
        wb_t e;
        mem_ready = 1'b1; mem_rdata = 32'h11223344;
        opcode = 6'h23; address = 32'h40; dest_reg = 5'd3; in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (wb_valid === 1'b1) begin
                if (npul < 3) pcyc[npul] = c;
                npul++;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected: wb_valid at cycle %0d with empty scoreboard", c);
                end else begin
                    e = sb_q.pop_front();
                    if (wb_reg !== e.rd || wb_data !== e.data) begin
                        n_fail++; $display("FAIL b2b_data: got reg=%0d data=%h exp reg=%0d data=%h", wb_reg, wb_data, e.rd, e.data);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                acc++;
                sb_q.push_back('{rd: 5'd3, data: 32'h11223344});
            end
            @(negedge clock);
            if (acc == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0; mem_ready = 1'b0;
        n_tests++;
        if (npul != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses exp 3", npul);
        end else if (pcyc[1] - pcyc[0] != 3 || pcyc[2] - pcyc[1] != 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d,%0d cycles exp 3,3", pcyc[1] - pcyc[0], pcyc[2] - pcyc[1]);
        end
        sb_q.delete();
        @(negedge clock);
    endtask

    task automatic test_wait_limit();
        mem_ready = 1'b0;
        issue(6'h23, 32'h30, 32'h0, 5'd4);
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < int'(TMO); c++) begin
            n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL tmo_req_cyc%0d: got=%b exp=1", c, mem_req); end
            @(negedge clock);
        end
        n_tests++;
        if (mem_req !== 1'b0 || misalign !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL tmo_abort: got req=%b mis=%b wb=%b exp 0 1 0", mem_req, misalign, wb_valid);
        end
        @(negedge clock);
        n_tests++;
        if (misalign !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL tmo_after: got mis=%b rdy=%b wb=%b exp 0 1 0", misalign, in_ready, wb_valid);
        end
`else
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if (mem_req !== 1'b1 || misalign !== 1'b0) begin
                n_fail++; $display("FAIL wait_hold_cyc%0d: got req=%b mis=%b exp 1 0", c, mem_req, misalign);
            end
            @(negedge clock);
        end
        mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clock);
        mem_ready = 1'b0;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_reg !== 5'd4 || wb_data !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL wait_resp: got wb=%b reg=%0d data=%h exp 1 4 55aa55aa", wb_valid, wb_reg, wb_data);
        end
        @(negedge clock);
`endif
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_load_lanes();
        test_stores();
        test_misalign();
        test_unsupported();
        test_reset_mid();
        test_back_to_back();
        test_wait_limit();
        chk_en = 1'b0;
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
